// File: rtl/fifo_rd_drain.sv
// Read-side drain for the async FIFO: pops words, absorbs read latency, and
// streams them out through a 2-entry buffer. Optional FIFO_RD_DRAIN_CNT_EN adds rd_cnt.
module fifo_rd_drain #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             rclk,
    input  logic             rrstn,
    input  logic             en,
    input  logic             flush,
    input  logic             rempty,
    input  logic [WIDTH-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
`ifdef FIFO_RD_DRAIN_CNT_EN
    output logic [15:0]      rd_cnt,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             infl_q;
    logic             pop_out;
    logic             cap;
    logic [2:0]       level;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign busy    = (state_q != IDLE);
    assign pop_out = m_valid && m_ready;

    // Words buffered or in flight after this cycle's downstream transfer.
    assign level = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop_out};
    assign rinc  = rrstn && en && !rempty && !flush && (level < 3'd2);
    assign cap   = (RD_LAT == 0) ? rinc : infl_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            case ({cap, pop_out})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = rdata;
                    else               tail_d = rdata;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = rdata;
                    end else begin
                        head_d = rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            infl_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            infl_q <= (RD_LAT != 0) && rinc;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrstn) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (en) state_q <= RUN;
                RUN: begin
                    if (!en) state_q <= (infl_q || occ_q != 2'd0) ? STOP : IDLE;
                end
                STOP: begin
                    if (en)                            state_q <= RUN;
                    else if (!infl_q && occ_q == 2'd0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_DRAIN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge rclk) begin
        if (!rrstn)       cnt_q <= '0;
        else if (pop_out) cnt_q <= cnt_q + 16'd1;
    end

    assign rd_cnt = cnt_q;
`endif

endmodule
